// File: rtl/ecc_133_scrub_ctrl_pkg.sv
// Shared definitions for the 133b+9b ECC scrubber: code geometry, FSM
// state encoding and the SECDED syndrome / correction helpers.
package ecc_133_scrub_ctrl_pkg;

  localparam int ECC_DW   = 133;
  localparam int ECC_PW   = 9;
  // Highest Hamming codeword position (data + 8 check bits, 1-based).
  localparam int ECC_NPOS = ECC_DW + ECC_PW - 1;

  typedef enum logic [2:0] {
    SC_IDLE  = 3'd0,
    SC_WAIT  = 3'd1,
    SC_READ  = 3'd2,
    SC_CHECK = 3'd3,
    SC_WB    = 3'd4
  } scrub_state_e;

  // Returns {overall_parity_error, hamming_syndrome}. Check bit j sits at
  // codeword position 2**j; data bits fill the remaining positions from 3
  // upward. parity[8] is even parity over the whole word.
  function automatic logic [ECC_PW-1:0] ecc_syndrome(input logic [ECC_DW-1:0] data,
                                                     input logic [ECC_PW-1:0] parity);
    logic [ECC_PW-2:0] syn;
    int d;
    syn = parity[ECC_PW-2:0];
    d   = 0;
    for (int p = 3; p <= ECC_NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (data[d[7:0]]) syn ^= (ECC_PW-1)'(p);
        d++;
      end
    end
    return {(^data) ^ (^parity), syn};
  endfunction

  // Flip the data bit whose codeword position equals the syndrome; a
  // syndrome pointing at a check bit leaves the data untouched.
  function automatic logic [ECC_DW-1:0] ecc_correct(input logic [ECC_DW-1:0] data,
                                                    input logic [ECC_PW-2:0] syn);
    logic [ECC_DW-1:0] c;
    int d;
    c = data;
    d = 0;
    for (int p = 3; p <= ECC_NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (syn == (ECC_PW-1)'(p)) c[d[7:0]] = ~c[d[7:0]];
        d++;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ecc_133_scrub_ctrl_fault_detc.sv
// Dual-redundant SECDED checker. Two independent syndrome copies are
// compared; any divergence is reported as a checker fault.
module ecc_133_fault_detc
  import ecc_133_scrub_ctrl_pkg::*;
(
  input  logic [ECC_DW-1:0] data,
  input  logic [ECC_PW-1:0] parity,
  input  logic              fault_detc_en,
  input  logic              bypass,
  output logic              sbit_err,
  output logic              dbit_err,
  output logic              ecc_fault,
  output logic [ECC_DW-1:0] corr_data
);

  logic [ECC_PW-1:0] chk_a;
  logic [ECC_PW-1:0] chk_b;
  logic [ECC_PW-2:0] syn;
  logic              ovr;

  // Two copies of the same syndrome tree; they must stay physically separate.
  assign chk_a = ecc_syndrome(data, parity);
  assign chk_b = ecc_syndrome(data, parity);
  assign {ovr, syn} = chk_a;

  // Odd overall parity with an in-range syndrome is correctable; anything
  // else with a nonzero syndrome is uncorrectable.
  assign sbit_err  = !bypass && ovr && (syn <= (ECC_PW-1)'(ECC_NPOS));
  assign dbit_err  = !bypass && ((!ovr && syn != '0) || (ovr && syn > (ECC_PW-1)'(ECC_NPOS)));
  assign ecc_fault = !bypass && fault_detc_en && (chk_a != chk_b);
  assign corr_data = ecc_correct(data, syn);

endmodule

// File: rtl/ecc_133_scrub_ctrl.sv
// Background scrubber for the ECC-protected FIFO RAM: walks every entry,
// writes back corrected data on single-bit errors, counts events, and
// always yields the RAM port to functional traffic.
module ecc_133_scrub_ctrl
  import ecc_133_scrub_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = ECC_DW,
  parameter int PARITY_WIDTH = ECC_PW,
  parameter int ADDR_WIDTH   = 6,
  parameter int DEPTH        = 64,
  parameter int CNT_WIDTH    = 8,
  parameter int IVL_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scrub_en,
  input  logic [IVL_WIDTH-1:0]    scrub_interval,
  input  logic                    ecc_fault_detc_en,
  input  logic                    cnt_clr,
  input  logic                    func_req,
  input  logic                    func_wr_en,
  input  logic [ADDR_WIDTH-1:0]   func_wr_addr,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  input  logic [PARITY_WIDTH-1:0] mem_rd_parity,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic                    err_vld,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  output logic                    dbit_irq,
  output logic                    pass_done
);

  localparam logic [2:0] IDLE  = SC_IDLE;
  localparam logic [2:0] WAIT  = SC_WAIT;
  localparam logic [2:0] READ  = SC_READ;
  localparam logic [2:0] CHECK = SC_CHECK;
  localparam logic [2:0] WB    = SC_WB;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [IVL_WIDTH-1:0]  ivl_cnt;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  sbit_err, dbit_err, ecc_fault;
  logic [DATA_WIDTH-1:0] corr_data;
  logic                  race, last, adv;
  logic                  log_fault, log_dbit, log_sbit;

  ecc_133_fault_detc u_fault_detc (
    .data          (mem_rd_data),
    .parity        (mem_rd_parity),
    .fault_detc_en (ecc_fault_detc_en),
    .bypass        (1'b0),
    .sbit_err      (sbit_err),
    .dbit_err      (dbit_err),
    .ecc_fault     (ecc_fault),
    .corr_data     (corr_data)
  );

  // A functional write to the entry being scrubbed makes our copy stale.
  assign race        = func_wr_en && (func_wr_addr == addr);
  assign last        = (addr == ADDR_WIDTH'(DEPTH - 1));
  assign mem_rd_en   = (state == READ) && scrub_en && !func_req;
  assign mem_rd_addr = addr;
  assign mem_wr_en   = (state == WB) && !func_req && !race;
  assign mem_wr_addr = addr;
  assign mem_wr_data = wb_data;

  assign log_fault = (state == CHECK) && ecc_fault;
  assign log_dbit  = (state == CHECK) && !ecc_fault && dbit_err;
  assign log_sbit  = (state == CHECK) && !ecc_fault && !dbit_err && sbit_err;

  // Current entry is finished this cycle: move to the next address.
  always_comb begin
    adv = 1'b0;
    case (state)
      CHECK:   adv = !log_sbit || race;
      WB:      adv = !func_req || race;
      default: adv = 1'b0;
    endcase
  end

  // Scrub FSM, address walk and interval timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      ivl_cnt   <= '0;
      wb_data   <= '0;
      pass_done <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      if (adv) begin
        addr      <= last ? '0 : addr + 1'b1;
        pass_done <= last;
        ivl_cnt   <= scrub_interval;
        state     <= scrub_en ? WAIT : IDLE;
      end else begin
        case (state)
          IDLE: if (scrub_en) begin
            ivl_cnt <= scrub_interval;
            state   <= WAIT;
          end
          WAIT: begin
            if (!scrub_en)           state   <= IDLE;
            else if (ivl_cnt == '0)  state   <= READ;
            else                     ivl_cnt <= ivl_cnt - 1'b1;
          end
          READ: begin
            if (!scrub_en)      state <= IDLE;
            else if (!func_req) state <= CHECK;
          end
          CHECK: begin
            wb_data <= corr_data;
            state   <= WB;
          end
          WB:      state <= WB;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Event log and saturating counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vld   <= 1'b0;
      err_addr  <= '0;
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      fault_cnt <= '0;
      dbit_irq  <= 1'b0;
    end else begin
      err_vld <= log_fault || log_dbit || log_sbit;
      if (log_fault || log_dbit || log_sbit) err_addr <= addr;
      if (cnt_clr) begin
        sbit_cnt  <= '0;
        dbit_cnt  <= '0;
        fault_cnt <= '0;
        dbit_irq  <= 1'b0;
      end else begin
        if (log_sbit  && sbit_cnt  != '1) sbit_cnt  <= sbit_cnt  + 1'b1;
        if (log_dbit  && dbit_cnt  != '1) dbit_cnt  <= dbit_cnt  + 1'b1;
        if (log_fault && fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
        if (log_fault || log_dbit)        dbit_irq  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecc_133_scrub_ctrl.sv
// Directed bench for the ECC scrubber with a 4-entry RAM model that
// re-encodes parity on write and supports one-shot and stuck-bit corruption.
module tb_ecc_133_scrub_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         scrub_en = 1'b0;
  logic [15:0]  scrub_interval = 16'd2;
  logic         ecc_fault_detc_en = 1'b1;
  logic         cnt_clr = 1'b0;
  logic         func_req = 1'b0;
  logic         func_wr_en = 1'b0;
  logic [5:0]   func_wr_addr = '0;
  logic         mem_rd_en, mem_wr_en, err_vld, dbit_irq, pass_done;
  logic [5:0]   mem_rd_addr, mem_wr_addr, err_addr;
  logic [132:0] mem_rd_data = '0;
  logic [8:0]   mem_rd_parity = '0;
  logic [132:0] mem_wr_data;
  logic [7:0]   sbit_cnt, dbit_cnt, fault_cnt;

  ecc_133_scrub_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
    .ecc_fault_detc_en(ecc_fault_detc_en), .cnt_clr(cnt_clr), .func_req(func_req),
    .func_wr_en(func_wr_en), .func_wr_addr(func_wr_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_rd_parity(mem_rd_parity),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .err_vld(err_vld), .err_addr(err_addr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .fault_cnt(fault_cnt), .dbit_irq(dbit_irq), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  // Reference SECDED encoder: check bits at positions 2**j, data elsewhere.
  function automatic logic [8:0] enc(input logic [132:0] d);
    logic [7:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 141; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) c = c ^ 8'(p);
        k++;
      end
    end
    return {(^d) ^ (^c), c};
  endfunction

  function automatic logic [132:0] pat(input int a);
    logic [159:0] w;
    for (int k = 0; k < 5; k++) w[k*32 +: 32] = 32'(32'h9E3779B9 * (a + 1)) ^ 32'(k * 32'h01234567);
    return w[132:0];
  endfunction

  // RAM model
  logic [132:0] ram_d [4];
  logic [8:0]   ram_p [4];
  logic [132:0] stuck_m [4];
  logic         tb_init = 1'b0, inj_go = 1'b0;
  logic [1:0]   inj_a = '0;
  logic [132:0] inj_m = '0;
  logic [5:0]   rd_log [64];
  int rd_n = 0, wr_n = 0, ev_n = 0, pd_n = 0;
  int n_chk = 0, n_err = 0;
  int lat, wlat, tgt, wr0;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int a = 0; a < 4; a++) begin
        ram_d[a] <= pat(a);
        ram_p[a] <= enc(pat(a));
      end
    end else if (inj_go) begin
      ram_d[inj_a] <= ram_d[inj_a] ^ inj_m;
    end
    if (mem_wr_en) begin
      ram_d[mem_wr_addr[1:0]] <= mem_wr_data;
      ram_p[mem_wr_addr[1:0]] <= enc(mem_wr_data);
      wr_n <= wr_n + 1;
    end
    if (mem_rd_en) begin
      mem_rd_data   <= ram_d[mem_rd_addr[1:0]] ^ stuck_m[mem_rd_addr[1:0]];
      mem_rd_parity <= ram_p[mem_rd_addr[1:0]];
      if (rd_n < 64) rd_log[rd_n] <= mem_rd_addr;
      rd_n <= rd_n + 1;
    end
    if (err_vld)   ev_n <= ev_n + 1;
    if (pass_done) pd_n <= pd_n + 1;
  end

  task automatic chk(input string tag, input logic [132:0] obs, input logic [132:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic inject(input logic [1:0] a, input logic [132:0] m);
    @(negedge clk);
    inj_a = a; inj_m = m; inj_go = 1'b1;
    @(negedge clk);
    inj_go = 1'b0;
  endtask

  task automatic reinit();
    @(negedge clk);
    tb_init = 1'b1;
    @(negedge clk);
    tb_init = 1'b0;
  endtask

  // Enable until n more reads are issued, then drop enable while in CHECK.
  task automatic run_reads(input int n, input string tag);
    int target;
    target = rd_n + n;
    scrub_en = 1'b1;
    for (int c = 0; c < 400 && rd_n < target; c++) @(negedge clk);
    scrub_en = 1'b0;
    chk({tag, "_rd_timeout"}, 133'(rd_n >= target), 133'd1);
    repeat (6) @(negedge clk);
  endtask

  // Cycles (negedges) until mem_rd_en; func_req drops at cycle drop_at.
  task automatic wait_rd(input int drop_at, output int l);
    l = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == drop_at) func_req = 1'b0;
      #1;
      if (mem_rd_en) begin
        l = c;
        break;
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 4; a++) stuck_m[a] = '0;
    rst_n = 1'b0;
    tb_init = 1'b1;
    repeat (2) @(negedge clk);
    tb_init = 1'b0;
    // reset state
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_err_vld", err_vld, 0);
    chk("rst_cnts", {sbit_cnt, dbit_cnt, fault_cnt, dbit_irq, pass_done}, 0);
    rst_n = 1'b1;

    // 1: clean pass over 4 entries
    run_reads(5, "t1");
    chk("t1_addr0", rd_log[0], 0);
    chk("t1_addr1", rd_log[1], 1);
    chk("t1_addr2", rd_log[2], 2);
    chk("t1_addr3", rd_log[3], 3);
    chk("t1_addr4", rd_log[4], 0);
    chk("t1_pass_done", pd_n, 1);
    chk("t1_cnts", {sbit_cnt, dbit_cnt, fault_cnt, dbit_irq}, 0);
    chk("t1_no_events", ev_n, 0);

    // 2: single-bit error at addr 2 (next scrub addr is 1)
    inject(2'd2, 133'd1 << 5);
    run_reads(2, "t2");
    chk("t2_sbit_cnt", sbit_cnt, 1);
    chk("t2_err_addr", err_addr, 2);
    chk("t2_ev_n", ev_n, 1);
    chk("t2_wr_n", wr_n, 1);
    chk("t2_ram_fixed", ram_d[2], pat(2));
    chk("t2_dbit_cnt", dbit_cnt, 0);
    run_reads(4, "t2b");
    chk("t2_reread_addr", rd_log[rd_n - 1], 2);
    chk("t2_reread_clean", sbit_cnt, 1);
    chk("t2_reread_wr_n", wr_n, 1);
    chk("t2_pass_done", pd_n, 2);

    // 3: double-bit error at addr 1 (next scrub addr is 3)
    inject(2'd1, (133'd1 << 0) | (133'd1 << 100));
    run_reads(3, "t3");
    chk("t3_dbit_cnt", dbit_cnt, 1);
    chk("t3_dbit_irq", dbit_irq, 1);
    chk("t3_err_addr", err_addr, 1);
    chk("t3_no_wb", wr_n, 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("t3_clr_dbit", dbit_cnt, 0);
    chk("t3_clr_irq", dbit_irq, 0);
    chk("t3_clr_sbit", sbit_cnt, 0);
    reinit();

    // 4: read latency from IDLE is 4, and 9 with func_req held 5 READ cycles
    scrub_en = 1'b1;
    wait_rd(0, lat);
    chk("t4_rd_lat", lat, 4);
    chk("t4_rd_addr", mem_rd_addr, 2);
    @(negedge clk); scrub_en = 1'b0;
    repeat (5) @(negedge clk);
    scrub_en = 1'b1; func_req = 1'b1;
    wait_rd(9, lat);
    chk("t4_rd_stall_lat", lat, 9);
    chk("t4_rd_stall_addr", mem_rd_addr, 3);
    @(negedge clk); scrub_en = 1'b0;
    repeat (5) @(negedge clk);
    // write-back stalled 5 cycles (next addr 0)
    inject(2'd0, 133'd1 << 7);
    scrub_en = 1'b1;
    wait_rd(0, lat);
    wlat = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) begin scrub_en = 1'b0; func_req = 1'b1; end
      if (j == 7) func_req = 1'b0;
      #1;
      if (mem_wr_en) begin
        wlat = j;
        break;
      end
    end
    chk("t4_wb_stall_lat", wlat, 7);
    chk("t4_wb_addr", mem_wr_addr, 0);
    chk("t4_wb_data", mem_wr_data, pat(0));
    repeat (4) @(negedge clk);
    chk("t4_wb_wr_n", wr_n, 2);
    // functional write to the scrub addr during WB cancels (next addr 1)
    inject(2'd1, 133'd1 << 9);
    scrub_en = 1'b1;
    wait_rd(0, lat);
    @(negedge clk); scrub_en = 1'b0; func_req = 1'b1;
    @(negedge clk); func_wr_en = 1'b1; func_wr_addr = 6'd1;
    #1;
    chk("t4_race_wr_en", mem_wr_en, 0);
    @(negedge clk); func_req = 1'b0; func_wr_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_race_no_wb", wr_n, 2);
    chk("t4_race_sbit_cnt", sbit_cnt, 2);
    reinit();

    // 5: saturation with a stuck bit on every entry, interval 0
    for (int a = 0; a < 4; a++) stuck_m[a] = 133'd1 << 3;
    scrub_interval = 16'd0;
    tgt = ev_n + 300;
    scrub_en = 1'b1;
    for (int c = 0; c < 5000 && ev_n < tgt; c++) @(negedge clk);
    chk("t5_ev_timeout", 133'(ev_n >= tgt), 133'd1);
    chk("t5_sbit_sat", sbit_cnt, 255);
    chk("t5_dbit_zero", dbit_cnt, 0);
    wait_rd(0, lat);
    @(negedge clk); cnt_clr = 1'b1; scrub_en = 1'b0;
    @(negedge clk); cnt_clr = 1'b0;
    #1;
    chk("t5_clr_event", err_vld, 1);
    chk("t5_clr_wins", sbit_cnt, 0);
    repeat (5) @(negedge clk);
    for (int a = 0; a < 4; a++) stuck_m[a] = '0;
    scrub_interval = 16'd2;
    reinit();

    // 6: redundant-checker mismatch
    force dut.u_fault_detc.chk_b = 9'h1ff;
    ecc_fault_detc_en = 1'b0;
    run_reads(1, "t6a");
    chk("t6_masked_fault", fault_cnt, 0);
    chk("t6_masked_irq", dbit_irq, 0);
    ecc_fault_detc_en = 1'b1;
    run_reads(1, "t6b");
    chk("t6_fault_cnt", fault_cnt, 1);
    chk("t6_fault_irq", dbit_irq, 1);
    chk("t6_fault_dbit", dbit_cnt, 0);
    inject(mem_rd_addr[1:0], (133'd1 << 1) | (133'd1 << 2));
    wr0 = wr_n;
    run_reads(1, "t6c");
    chk("t6_prio_fault", fault_cnt, 2);
    chk("t6_prio_dbit", dbit_cnt, 0);
    chk("t6_prio_no_wb", wr_n, wr0);
    release dut.u_fault_detc.chk_b;
    reinit();
    // reset asserted while in WB: no write, outputs back to 0
    inject(mem_rd_addr[1:0], 133'd1 << 11);
    wr0 = wr_n;
    scrub_en = 1'b1;
    wait_rd(0, lat);
    @(negedge clk); func_req = 1'b1;
    @(negedge clk); rst_n = 1'b0; func_req = 1'b0; scrub_en = 1'b0;
    #1;
    chk("t6_rst_wr_en", mem_wr_en, 0);
    chk("t6_rst_cnts", {sbit_cnt, dbit_cnt, fault_cnt, dbit_irq, err_vld}, 0);
    chk("t6_rst_outs", {mem_wr_data, err_addr, mem_rd_addr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_rst_no_wb", wr_n, wr0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
